// File: rtl/tel_frame_reader.sv
`timescale 1ns/1ps
// Telemetry frame reader: reads a monitor address window into a framed word stream
// (sync header, data words, 16-bit additive checksum) with stall timeout.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for tel_req_in; read strobe and valid low
// HDR   | sync word presented, waiting for accept
// SNAP  | first rd edge at START_ADDR, monitor captures its snapshot
// FETCH | rd held, monitor data settling for current address
// LOAD  | monitor data captured into output word and checksum
// SEND  | data word presented, waiting for accept
// CSUM  | checksum word presented, waiting for accept
module tel_frame_reader #(
   parameter logic [7:0]  START_ADDR  = 8'h19,
   parameter logic [7:0]  END_ADDR    = 8'h3B,
   parameter logic [15:0] SYNC_WORD   = 16'hEB90,
   parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        tel_req_in,
   input  logic [15:0] mon_data_in,
   input  logic        tx_ready_in,
   output logic        rd_out,
   output logic [7:0]  rd_addr_out,
   output logic [15:0] tx_data_out,
   output logic        tx_valid_out,
   output logic        busy_out,
   output logic        frame_done_out,
   output logic        timeout_out,
   output logic        req_overrun_out,
   output logic [15:0] frame_cnt_out
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] HDR   = 3'd1;
   localparam logic [2:0] SNAP  = 3'd2;
   localparam logic [2:0] FETCH = 3'd3;
   localparam logic [2:0] LOAD  = 3'd4;
   localparam logic [2:0] SEND  = 3'd5;
   localparam logic [2:0] CSUM  = 3'd6;

   logic [2:0]  state;
   logic [15:0] csum;
   logic [15:0] stall_cnt;
   logic        accept;
   logic        stalled;
   logic        stall_tc;

   assign accept   = tx_valid_out & tx_ready_in;
   assign stalled  = tx_valid_out & ~tx_ready_in;
   // Abort on the stalled cycle that brings the count up to TIMEOUT_CYC.
   assign stall_tc = stalled && (stall_cnt == (TIMEOUT_CYC - 16'd1));
   assign busy_out = (state != IDLE);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         stall_cnt <= '0;
      end else if (state == IDLE || accept || stall_tc) begin
         stall_cnt <= '0;
      end else if (stalled) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         req_overrun_out <= 1'b0;
      end else begin
         req_overrun_out <= tel_req_in & busy_out;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state          <= IDLE;
         csum           <= '0;
         rd_out         <= 1'b0;
         rd_addr_out    <= '0;
         tx_data_out    <= '0;
         tx_valid_out   <= 1'b0;
         frame_done_out <= 1'b0;
         timeout_out    <= 1'b0;
         frame_cnt_out  <= '0;
      end else begin
         frame_done_out <= 1'b0;
         timeout_out    <= 1'b0;
         if (stall_tc) begin
            rd_out       <= 1'b0;
            rd_addr_out  <= '0;
            tx_valid_out <= 1'b0;
            timeout_out  <= 1'b1;
            state        <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  rd_out       <= 1'b0;
                  rd_addr_out  <= '0;
                  tx_valid_out <= 1'b0;
                  if (tel_req_in) begin
                     tx_data_out  <= SYNC_WORD;
                     tx_valid_out <= 1'b1;
                     csum         <= '0;
                     state        <= HDR;
                  end
               end
               HDR: begin
                  if (accept) begin
                     tx_valid_out <= 1'b0;
                     rd_out       <= 1'b1;
                     rd_addr_out  <= START_ADDR;
                     state        <= SNAP;
                  end
               end
               SNAP:  state <= FETCH;
               FETCH: state <= LOAD;
               LOAD: begin
                  tx_data_out  <= mon_data_in;
                  tx_valid_out <= 1'b1;
                  csum         <= csum + mon_data_in;
                  state        <= SEND;
               end
               SEND: begin
                  // rd_out stays high across words so the monitor never re-snapshots.
                  if (accept) begin
                     if (rd_addr_out == END_ADDR) begin
                        tx_data_out <= csum;
                        rd_out      <= 1'b0;
                        state       <= CSUM;
                     end else begin
                        rd_addr_out  <= rd_addr_out + 8'd1;
                        tx_valid_out <= 1'b0;
                        state        <= FETCH;
                     end
                  end
               end
               CSUM: begin
                  if (accept) begin
                     tx_valid_out   <= 1'b0;
                     rd_addr_out    <= '0;
                     frame_done_out <= 1'b1;
                     frame_cnt_out  <= frame_cnt_out + 16'd1;
                     state          <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/tel_frame_reader.md
TEL_FRAME_READER -- requirements
Module: tel_frame_reader

Interface
REQ-001 SHALL have parameter START_ADDR, default 8'h19, meaning the first monitor address read; this address also triggers the snapshot.
REQ-002 SHALL have parameter END_ADDR, default 8'h3B, meaning the last monitor address read.
REQ-003 SHALL have parameter SYNC_WORD, default 16'hEB90, meaning the frame header word.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 16'd50000, meaning the stall limit in cycles (1 ms at 50 MHz).
REQ-005 clk_in  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-006 rst_in  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 tel_req_in  input  1  frame request, sampled high for one or more cycles.
REQ-008 mon_data_in  input  16  monitor read data; valid one cycle after rd_out/rd_addr_out are presented.
REQ-009 tx_ready_in  input  1  downstream accept.
REQ-010 rd_out  output  1  monitor read strobe, registered.
REQ-011 rd_addr_out  output  8  monitor read address, registered.
REQ-012 tx_data_out  output  16  frame word, registered.
REQ-013 tx_valid_out  output  1  frame word valid; a word is accepted when tx_valid_out & tx_ready_in.
REQ-014 busy_out  output  1  high whenever the FSM is not in IDLE.
REQ-015 frame_done_out  output  1  one-cycle pulse when the checksum word is accepted.
REQ-016 timeout_out  output  1  one-cycle pulse on a stall abort.
REQ-017 req_overrun_out  output  1  one-cycle pulse when tel_req_in is high while busy.
REQ-018 frame_cnt_out  output  16  completed-frame counter; wraps from 16'hFFFF to 0.

Function
REQ-019 FSM states SHALL be IDLE, HDR, SNAP, FETCH, LOAD, SEND, CSUM.
REQ-020 IDLE: rd_out=0, rd_addr_out=0, tx_valid_out=0; on tel_req_in=1, load tx_data_out=SYNC_WORD, set tx_valid_out=1, clear checksum, go to HDR.
REQ-021 HDR: hold the word until accepted; on accept, tx_valid_out=0, rd_out=1, rd_addr_out=START_ADDR, go to SNAP.
REQ-022 SNAP SHALL last exactly 1 cycle, giving the monitor a 0->1 rd edge at START_ADDR so it captures its snapshot; rd_out and rd_addr_out are held; go to FETCH.
REQ-023 FETCH SHALL last exactly 1 cycle with rd_out=1 and the address held; go to LOAD.
REQ-024 LOAD SHALL last exactly 1 cycle: register mon_data_in into tx_data_out, set tx_valid_out=1, add mon_data_in to the checksum; go to SEND.
REQ-025 SEND: hold tx_data_out and rd_addr_out until accepted.
REQ-025a On accept in SEND with rd_addr_out==END_ADDR: load tx_data_out=checksum, go to CSUM.
REQ-025b On accept in SEND otherwise: rd_addr_out+1, tx_valid_out=0, go to FETCH.
REQ-026 rd_out SHALL stay continuously 1 from SNAP through the last SEND, so the monitor sees no further rising edge and does not re-snapshot.
REQ-027 CSUM: rd_out=0; on accept, tx_valid_out=0, pulse frame_done_out, increment frame_cnt_out, go to IDLE.
REQ-028 Checksum SHALL be the 16-bit sum of all data words (excluding header and checksum), modulo 2^16, carries discarded.
REQ-029 Frame length SHALL be END_ADDR-START_ADDR+3 words (37 with defaults).
REQ-030 Minimum latency: 3 cycles per data word with tx_ready_in tied high; header accepted the cycle after the request.
REQ-031 tel_req_in while busy SHALL be ignored and SHALL pulse req_overrun_out once per cycle it is high; no request is queued.
REQ-032 Stall counter SHALL increment each cycle tx_valid_out & ~tx_ready_in, and SHALL clear on every accept and in IDLE.
REQ-033 When the stall count reaches TIMEOUT_CYC, the block SHALL abort: rd_out=0, tx_valid_out=0, pulse timeout_out, go to IDLE, frame_cnt_out unchanged.
REQ-034 tx_data_out SHALL NOT change while tx_valid_out=1 and the word has not been accepted.

Reset
REQ-035 On rst_in=0 all outputs SHALL go to 0 asynchronously; the FSM goes to IDLE and the checksum and stall counter clear.
REQ-036 A reset mid-frame SHALL discard the frame without emitting frame_done_out; after release, a new tel_req_in starts a fresh frame with a header.

Verification
REQ-037 Monitor model returns {8'h00, addr}; tx_ready_in=1; pulse tel_req_in -> 37 words: EB90, 0019..003B, checksum 05BE; frame_done_out one pulse; frame_cnt_out=1.
REQ-038 rd_out shows exactly one 0->1 edge per frame, at rd_addr_out=8'h19, and stays 1 until CSUM.
REQ-039 Random tx_ready_in toggling -> identical word sequence and checksum; no word changes while stalled.
REQ-040 tx_ready_in=0 after the 5th word for 50000 cycles -> timeout_out pulses, busy_out=0, frame_cnt_out unchanged; the next request yields a full frame.
REQ-041 tel_req_in held high 3 cycles into a frame -> req_overrun_out pulses for the busy cycles; only one frame is emitted.
REQ-042 rst_in asserted during the 10th data word -> all outputs 0 immediately; the following request yields a complete frame starting with EB90.
